// File: rtl/counter_pkg.sv
// Shared helpers for the performance-counter bank.
// Optional feature macro used by the bank: CNT_OVF_IRQ_EN.
package counter_pkg;

  // Increment applied per event when the instantiating module does not override STEP.
  localparam int unsigned DEFAULT_STEP = 1;

  // Select-field width: one bit minimum so a single-channel bank still has a select port.
  function automatic int unsigned sel_w(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // All-ones value of width w, for widths up to 64 bits.
  function automatic logic [63:0] all_ones(int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One counter channel: count register with increment, software load and optional saturation.
// Reports a one-cycle overflow pulse; the sticky flag is kept by the bank.
module perf_counter_slice
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter bit               SAT   = 1'b0,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(DEFAULT_STEP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             inhibit,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf_set
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // Extra top bit captures the carry out of the increment.
  assign sum = {1'b0, cnt_q} + {1'b0, STEP};

  // Next count: a software write takes priority and swallows any same-cycle event.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (wr_en) begin
      cnt_d = wr_data;
    end else if (inc_en && !inhibit) begin
      ovf_set = sum[WIDTH];
      if (sum[WIDTH] && SAT) begin
        cnt_d = '1;
      end else begin
        cnt_d = sum[WIDTH-1:0];
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NCNT independent event counters with sticky overflow and a registered read port.
// Optional feature: define CNT_OVF_IRQ_EN to add the irq_mask input and registered irq output.
module perf_counter_bank
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NCNT     = 4,
  parameter logic [NCNT-1:0]  SAT_MASK = '0,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(DEFAULT_STEP)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCNT-1:0]          inc_en,
  input  logic [NCNT-1:0]          inhibit,
  input  logic                     wr_en,
  input  logic [sel_w(NCNT)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NCNT-1:0]          ovf_clr,
  input  logic [sel_w(NCNT)-1:0]   rd_sel,
`ifdef CNT_OVF_IRQ_EN
  input  logic [NCNT-1:0]          irq_mask,
  output logic                     irq,
`endif
  output logic [WIDTH-1:0]         rd_data,
  output logic [NCNT-1:0]          ovf
);

  localparam int unsigned SEL_W = sel_w(NCNT);

  logic [WIDTH-1:0] cnt [NCNT];
  logic [NCNT-1:0]  wr_hit;
  logic [NCNT-1:0]  ovf_set;
  logic [NCNT-1:0]  ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  for (genvar i = 0; i < NCNT; i++) begin : g_ch
    // Out-of-range selects match no channel, so such writes are dropped.
    assign wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));

    perf_counter_slice #(
      .WIDTH (WIDTH),
      .SAT   (SAT_MASK[i]),
      .STEP  (STEP)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .inc_en  (inc_en[i]),
      .inhibit (inhibit[i]),
      .wr_en   (wr_hit[i]),
      .wr_data (wr_data),
      .cnt     (cnt[i]),
      .ovf_set (ovf_set[i])
    );
  end

  // Sticky overflow: a new overflow outranks a same-cycle clear.
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Read mux over pre-update counts; unmatched selects read as zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = cnt[i];
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

`ifdef CNT_OVF_IRQ_EN
  logic irq_q;

  // Interrupt follows the next-state flags so it rises on the same edge as ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(ovf_d & irq_mask);
    end
  end

  assign irq = irq_q;
`endif

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: a driver updates an arithmetic reference model
// and queues the expected response; a monitor pops and compares each cycle.
module tb_perf_counter_bank;

  localparam int         W    = 8;
  localparam int         N    = 4;
  localparam int         STEP = 1;
  localparam int         MAXV = 255;
  localparam logic [3:0] SM   = 4'b0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] inc_en, inhibit, ovf_clr, ovf;
  logic       wr_en;
  logic [1:0] wr_sel, rd_sel;
  logic [7:0] wr_data, rd_data;
`ifdef CNT_OVF_IRQ_EN
  logic [3:0] irq_mask;
  logic       irq;
  logic [2:0] s_mask;
  logic       s_irq;
`endif

  // Second bank: three channels, STEP=3, wrapping, for out-of-range selects and step size.
  logic [2:0] s_inc, s_inh, s_clr, s_ovf;
  logic       s_wr_en;
  logic [1:0] s_wr_sel, s_rd_sel;
  logic [7:0] s_wr_data, s_rd;

  perf_counter_bank #(
    .WIDTH    (W),
    .NCNT     (N),
    .SAT_MASK (SM),
    .STEP     (8'd1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (inc_en),
    .inhibit  (inhibit),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .rd_sel   (rd_sel),
`ifdef CNT_OVF_IRQ_EN
    .irq_mask (irq_mask),
    .irq      (irq),
`endif
    .rd_data  (rd_data),
    .ovf      (ovf)
  );

  perf_counter_bank #(
    .WIDTH    (W),
    .NCNT     (3),
    .SAT_MASK (3'b000),
    .STEP     (8'd3)
  ) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (s_inc),
    .inhibit  (s_inh),
    .wr_en    (s_wr_en),
    .wr_sel   (s_wr_sel),
    .wr_data  (s_wr_data),
    .ovf_clr  (s_clr),
    .rd_sel   (s_rd_sel),
`ifdef CNT_OVF_IRQ_EN
    .irq_mask (s_mask),
    .irq      (s_irq),
`endif
    .rd_data  (s_rd),
    .ovf      (s_ovf)
  );

  typedef struct {
    int rd;
    int ovf;
    int irq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mcnt[N];
  bit [3:0] movf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply the current inputs to the reference model, queue the expectation, run one edge.
  task automatic tick();
    exp_t e;
    int   v;
    bit   setf;
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      movf = '0;
      e.rd = 0;
      e.ovf = 0;
      e.irq = 0;
    end else begin
      e.rd = mcnt[rd_sel];
      for (int i = 0; i < N; i++) begin
        setf = 1'b0;
        if (wr_en && int'(wr_sel) == i) begin
          mcnt[i] = int'(wr_data);
        end else if (inc_en[i] && !inhibit[i]) begin
          v = mcnt[i] + STEP;
          if (v > MAXV) begin
            setf = 1'b1;
            v = SM[i] ? MAXV : v - (MAXV + 1);
          end
          mcnt[i] = v;
        end
        movf[i] = setf | (movf[i] & ~ovf_clr[i]);
      end
      e.ovf = int'(movf);
`ifdef CNT_OVF_IRQ_EN
      e.irq = int'(|(movf & irq_mask));
`else
      e.irq = 0;
`endif
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: rd_data/ovf are presented every cycle, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_rd_data", {24'd0, rd_data}, e.rd);
        chk("sb_ovf", {28'd0, ovf}, e.ovf);
`ifdef CNT_OVF_IRQ_EN
        chk("sb_irq", {31'd0, irq}, e.irq);
`endif
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inc_en = 4'hF; inhibit = '0; ovf_clr = '0;
    wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'hAB; rd_sel = 2'd0;
    s_inc = '0; s_inh = '0; s_clr = '0; s_wr_en = 1'b0; s_wr_sel = '0;
    s_wr_data = '0; s_rd_sel = '0;
`ifdef CNT_OVF_IRQ_EN
    irq_mask = '0; s_mask = '0;
`endif
    // Reset dominates events and writes.
    tick();
    tick();
    rst = 1'b0; inc_en = '0; wr_en = 1'b0;
    tick();
    chk("rst_rd", {24'd0, rd_data}, 32'h0);
    chk("rst_ovf", {28'd0, ovf}, 32'h0);

    // STEP=3 wrap, out-of-range write and read on the three-channel bank.
    s_wr_en = 1'b1; s_wr_sel = 2'd0; s_wr_data = 8'hFE; tick();
    s_wr_en = 1'b0; s_inc = 3'b001; tick();
    s_inc = '0; s_rd_sel = 2'd0; tick();
    chk("step3_wrap", {24'd0, s_rd}, 32'h01);
    chk("step3_ovf", {29'd0, s_ovf}, 32'h1);
    s_wr_en = 1'b1; s_wr_sel = 2'd3; s_wr_data = 8'h77; tick();
    s_wr_en = 1'b0; s_rd_sel = 2'd3; tick();
    chk("rd_oor", {24'd0, s_rd}, 32'h0);
    s_rd_sel = 2'd2; tick();
    chk("wr_oor_ch2", {24'd0, s_rd}, 32'h0);
    s_rd_sel = 2'd0; tick();
    chk("wr_oor_ch0", {24'd0, s_rd}, 32'h01);

    // Ten events on channel 0, then the same with three inhibited cycles.
    inc_en = 4'b0001; rd_sel = 2'd0;
    for (int k = 0; k < 10; k++) tick();
    inc_en = '0; tick();
    chk("count10", {24'd0, rd_data}, 32'd10);
    wr(2'd0, 8'h00);
    inc_en = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      inhibit = (k >= 3 && k < 6) ? 4'b0001 : 4'b0000;
      tick();
    end
    inc_en = '0; inhibit = '0; tick();
    chk("count_inhibit", {24'd0, rd_data}, 32'd7);
    rd_sel = 2'd1; tick();
    chk("ch1_idle", {24'd0, rd_data}, 32'd0);

    // Wrap and sticky overflow on channel 0.
    rd_sel = 2'd0;
    wr(2'd0, 8'hFE);
    inc_en = 4'b0001; tick();
    inc_en = '0; tick();
    chk("to_ff", {24'd0, rd_data}, 32'hFF);
    chk("to_ff_ovf", {31'd0, ovf[0]}, 32'h0);
    inc_en = 4'b0001; tick();
    inc_en = '0; tick();
    chk("wrap", {24'd0, rd_data}, 32'h00);
    chk("wrap_ovf", {31'd0, ovf[0]}, 32'h1);
    ovf_clr = 4'b0001; tick();
    ovf_clr = '0;
    chk("ovf_clr", {31'd0, ovf[0]}, 32'h0);
    wr(2'd0, 8'hFF);
    inc_en = 4'b0001; ovf_clr = 4'b0001; tick();
    inc_en = '0; ovf_clr = '0;
    chk("set_beats_clr", {31'd0, ovf[0]}, 32'h1);

    // Saturating channel 2.
    rd_sel = 2'd2;
    wr(2'd2, 8'hFF);
    inc_en = 4'b0100;
    repeat (3) tick();
    inc_en = '0; tick();
    chk("sat_hold", {24'd0, rd_data}, 32'hFF);
    chk("sat_ovf", {31'd0, ovf[2]}, 32'h1);

    // Write beats a same-cycle event; read returns the pre-edge value.
    rd_sel = 2'd1;
    wr(2'd1, 8'h30);
    wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h55; inc_en = 4'b0010; tick();
    wr_en = 1'b0; inc_en = '0;
    chk("rdw_old", {24'd0, rd_data}, 32'h30);
    tick();
    chk("wr_wins", {24'd0, rd_data}, 32'h55);
    wr(2'd3, 8'hAA);
    tick();
    chk("wr3_no_alias", {24'd0, rd_data}, 32'h55);

`ifdef CNT_OVF_IRQ_EN
    ovf_clr = 4'hF; tick();
    ovf_clr = '0; irq_mask = 4'b0001;
    wr(2'd0, 8'hFF);
    inc_en = 4'b0001; tick();
    inc_en = '0;
    chk("irq_rise", {31'd0, irq}, 32'h1);
    chk("irq_ovf", {31'd0, ovf[0]}, 32'h1);
    ovf_clr = 4'b0001; tick();
    ovf_clr = '0;
    chk("irq_clr", {31'd0, irq}, 32'h0);
    wr(2'd1, 8'hFF);
    inc_en = 4'b0010; tick();
    inc_en = '0;
    chk("irq_masked_ovf", {31'd0, ovf[1]}, 32'h1);
    chk("irq_masked", {31'd0, irq}, 32'h0);
`endif

    // Randomized traffic biased toward near-full counters.
    for (int k = 0; k < 800; k++) begin
      rst     = ($urandom_range(0, 99) == 0);
      inc_en  = 4'($urandom);
      inhibit = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_sel  = 2'($urandom);
      wr_data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      ovf_clr = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      rd_sel  = 2'($urandom);
`ifdef CNT_OVF_IRQ_EN
      irq_mask = 4'($urandom);
`endif
      tick();
    end
    rst = 1'b0; inc_en = '0; inhibit = '0; wr_en = 1'b0; ovf_clr = '0;
    tick();
    chk("sb_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
